// File: rtl/hyperram_responder.sv
// hyperram_responder: synthesizable target-side HyperRAM model (single data rate,
// one dq byte per clk while cs_n is low). Captures the 6-byte CA, waits LATENCY
// clks, then streams read data with an rwds strobe or absorbs byte-masked writes
// into an internal 2**ADDR_W x 16-bit memory. Register-space reads return
// ID0_VALUE; register-space writes take two bytes and discard them.
// Optional feature: define HYPERRAM_RESP_WRAP_EN to honour CA[45]=0 as a
// wrapped burst (address wraps within an aligned 16-word block).
module hyperram_responder #(
  parameter int          ADDR_W    = 8,
  parameter int          LATENCY   = 6,
  parameter logic [15:0] ID0_VALUE = 16'h0C81
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic [7:0] dq_in,
  input  logic       rwds_in,
  output logic [7:0] dq_out,
  output logic       dq_oe,
  output logic       rwds_out,
  output logic       rwds_oe,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, CA, LAT, READ, WRITE, REGWR, DONE
  } state_t;

  localparam int                LAT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);
  localparam int                DEPTH     = 2 ** ADDR_W;

  // A zero latency would collapse the LAT state; refuse to elaborate.
  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("hyperram_responder: LATENCY must be at least 1");
    end
  endgenerate

  state_t            state;
  logic [2:0]        ca_cnt;      // CA bytes received so far
  logic              is_read;     // CA[47]
  logic              is_reg;      // CA[46]
`ifdef HYPERRAM_RESP_WRAP_EN
  logic              is_wrap;     // ~CA[45]
`endif
  logic [LAT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] addr;
  logic              phase;       // 0: high byte, 1: low byte of current word

  logic [15:0]       mem [DEPTH];

  logic [ADDR_W-1:0] addr_nxt;
  logic [15:0]       rd_cur;
  logic [15:0]       rd_nxt;
  logic              mem_we_hi;
  logic              mem_we_lo;

  assign busy = (state != IDLE);

  // Next word address: linear increment, or modulo-16 inside the block for wrapped bursts.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    addr_nxt = addr + ADDR_W'(1);
`ifdef HYPERRAM_RESP_WRAP_EN
    if (is_wrap) begin
      addr_nxt = (addr & ~ADDR_W'(15)) | ((addr + ADDR_W'(1)) & ADDR_W'(15));
    end
`endif
  end

  // Read word source (memory or ID register) and write byte-lane enables.
  always_comb begin
    rd_cur    = is_reg ? ID0_VALUE : mem[addr];
    rd_nxt    = is_reg ? ID0_VALUE : mem[addr_nxt];
    mem_we_hi = (state == WRITE) && !cs_n && !phase && !rwds_in;
    mem_we_lo = (state == WRITE) && !cs_n &&  phase && !rwds_in;
  end

  // Memory array: byte-lane writes during WRITE bursts.
  // NOTE: the memory has no reset branch; contents survive rst_n and the array maps onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we_hi) mem[addr][15:8] <= dq_in;
    if (mem_we_lo) mem[addr][7:0]  <= dq_in;
  end

  // Transaction FSM with registered dq/rwds outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ca_cnt   <= '0;
      is_read  <= 1'b0;
      is_reg   <= 1'b0;
`ifdef HYPERRAM_RESP_WRAP_EN
      is_wrap  <= 1'b0;
`endif
      lat_cnt  <= '0;
      addr     <= '0;
      phase    <= 1'b0;
      dq_out   <= '0;
      dq_oe    <= 1'b0;
      rwds_out <= 1'b0;
      rwds_oe  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      dq_out   <= '0;
      dq_oe    <= 1'b0;
      rwds_out <= 1'b0;
      rwds_oe  <= 1'b0;
      if (cs_n) begin
        state   <= IDLE;
        ca_cnt  <= '0;
        lat_cnt <= '0;
        phase   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            is_read <= dq_in[7];
            is_reg  <= dq_in[6];
`ifdef HYPERRAM_RESP_WRAP_EN
            is_wrap <= ~dq_in[5];
`endif
            addr    <= ADDR_W'(dq_in[4:0]);
            ca_cnt  <= 3'd1;
            state   <= CA;
          end
          CA: begin
            ca_cnt <= ca_cnt + 3'd1;
            // Bytes 1..3 carry the upper word address, byte 4 is reserved, byte 5 holds CA[2:0].
            case (ca_cnt)
              3'd1, 3'd2, 3'd3: addr <= ADDR_W'({addr, dq_in});
              3'd5:             addr <= ADDR_W'({addr, dq_in[2:0]});
              default:          ;
            endcase
            if (ca_cnt == 3'd5) begin
              phase <= 1'b0;
              if (!is_read && is_reg) begin
                state <= REGWR;
              end else begin
                state   <= LAT;
                lat_cnt <= LAT_LOAD;
              end
            end
          end
          LAT: begin
            if (lat_cnt == '0) begin
              phase <= 1'b0;
              if (is_read) begin
                state    <= READ;
                dq_out   <= rd_cur[15:8];
                dq_oe    <= 1'b1;
                rwds_out <= 1'b1;
                rwds_oe  <= 1'b1;
              end else begin
                state <= WRITE;
              end
            end else begin
              lat_cnt <= lat_cnt - LAT_W'(1);
            end
          end
          READ: begin
            dq_oe   <= 1'b1;
            rwds_oe <= 1'b1;
            if (!phase) begin
              dq_out   <= rd_cur[7:0];
              rwds_out <= 1'b0;
              phase    <= 1'b1;
            end else begin
              addr     <= addr_nxt;
              dq_out   <= rd_nxt[15:8];
              rwds_out <= 1'b1;
              phase    <= 1'b0;
            end
          end
          WRITE: begin
            if (phase) addr <= addr_nxt;
            phase <= ~phase;
          end
          REGWR: begin
            if (phase) state <= DONE;
            phase <= ~phase;
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hyperram_responder.sv
// tb_hyperram_responder: directed bench for hyperram_responder. Stimulus tasks push
// the expected read bytes (value, rwds level, arrival cycle) into a queue; a
// negedge monitor pops one entry for every cycle the DUT drives dq.
module tb_hyperram_responder;

  localparam int ADDR_W  = 8;
  localparam int LATENCY = 6;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       cs_n    = 1'b1;
  logic [7:0] dq_in   = 8'h00;
  logic       rwds_in = 1'b0;
  logic [7:0] dq_out;
  logic       dq_oe;
  logic       rwds_out;
  logic       rwds_oe;
  logic       busy;

  hyperram_responder #(
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_n     (cs_n),
    .dq_in    (dq_in),
    .rwds_in  (rwds_in),
    .dq_out   (dq_out),
    .dq_oe    (dq_oe),
    .rwds_out (rwds_out),
    .rwds_oe  (rwds_oe),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       rwds;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every driven read byte must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && dq_oe !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read_byte: got dq_out=%0h at cycle %0d, expected no drive", dq_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (dq_out !== mon_e.data || rwds_out !== mon_e.rwds || rwds_oe !== 1'b1 || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL read_byte: got dq=%0h rwds=%0b rwds_oe=%0b cycle=%0d, expected dq=%0h rwds=%0b rwds_oe=1 cycle=%0d",
                   dq_out, rwds_out, rwds_oe, cyc, mon_e.data, mon_e.rwds, mon_e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ca(input logic [47:0] ca);
    for (int i = 0; i < 6; i++) begin
      cs_n  = 1'b0;
      dq_in = ca[47-8*i -: 8];
      tick();
    end
  endtask

  task automatic end_txn();
    cs_n    = 1'b1;
    dq_in   = 8'h00;
    rwds_in = 1'b0;
    tick();
    tick();
  endtask

  // Write up to 4 bytes; byte 0 is data[31:24], its mask bit is mask[3].
  task automatic do_write(input logic [47:0] ca, input int n, input logic [31:0] data, input logic [3:0] mask);
    send_ca(ca);
    repeat (LATENCY) tick();
    for (int i = 0; i < n; i++) begin
      dq_in   = data[31-8*i -: 8];
      rwds_in = mask[3-i];
      tick();
    end
    end_txn();
  endtask

  // Read up to 4 bytes; expected byte k arrives LATENCY+k cycles after the last CA edge.
  task automatic do_read(input string name, input logic [47:0] ca, input int n, input logic [31:0] data);
    int n0;
    send_ca(ca);
    n0 = cyc;
    check({name, "_busy"}, busy, 1);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{n0 + LATENCY + k, data[31-8*k -: 8], (k % 2 == 0) ? 1'b1 : 1'b0});
    end
    repeat (LATENCY + n - 1) tick();
    end_txn();
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    logic [31:0] wrap_exp;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check("rst_dq_oe", dq_oe, 0);
    check("rst_rwds_oe", rwds_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_dq_out", dq_out, 0);
    check("rst_rwds_out", rwds_out, 0);
    rst_n = 1'b1;
    tick();

    // Word 3/4 full write, then read back.
    do_write(48'h00_00_00_00_00_03, 4, 32'hCCCC_DDDD, 4'b0000);
    do_read("rd_w3", 48'h80_00_00_00_00_03, 4, 32'hCCCC_DDDD);

    // Masked high byte over AAAA.
    do_write(48'h20_00_00_00_00_05, 2, 32'hAAAA_0000, 4'b0000);
    do_write(48'h20_00_00_00_00_05, 2, 32'h1234_0000, 4'b1000);
    do_read("rd_mask", 48'hA0_00_00_00_00_05, 2, 32'hAA34_0000);

    // Linear burst across the top of memory: 255 -> 0.
    do_write(48'h20_00_00_1F_00_07, 4, 32'h1122_3344, 4'b0000);
    do_read("rd_top", 48'hA0_00_00_1F_00_07, 4, 32'h1122_3344);

    // Wrapped vs linear burst from 0x1F.
    do_write(48'h20_00_00_03_00_07, 2, 32'h1F1F_0000, 4'b0000);
    do_write(48'h20_00_00_02_00_00, 2, 32'h1010_0000, 4'b0000);
    do_write(48'h20_00_00_04_00_00, 2, 32'h2020_0000, 4'b0000);
`ifdef HYPERRAM_RESP_WRAP_EN
    wrap_exp = 32'h1F1F_1010;
`else
    wrap_exp = 32'h1F1F_2020;
`endif
    do_read("rd_wrap", 48'h80_00_00_03_00_07, 4, wrap_exp);

    // Register-space read.
    do_read("rd_id0", 48'hC0_00_00_00_00_00, 2, 32'h0C81_0000);

    // cs_n rises during latency: back to idle, never drives dq.
    send_ca(48'h80_00_00_00_00_03);
    tick();
    tick();
    cs_n = 1'b1;
    tick();
    check("abort_lat_busy", busy, 0);
    check("abort_lat_dq_oe", dq_oe, 0);
    repeat (LATENCY + 4) tick();
    check("abort_lat_quiet", dq_oe, 0);

    // cs_n low for a single cycle.
    cs_n  = 1'b0;
    dq_in = 8'h20;
    tick();
    check("one_cycle_busy", busy, 1);
    cs_n = 1'b1;
    tick();
    check("one_cycle_idle", busy, 0);

    // Register write: two bytes discarded, then DONE until cs_n rises.
    send_ca(48'h60_00_00_00_00_00);
    dq_in = 8'h55;
    tick();
    tick();
    repeat (4) tick();
    check("regwr_done_busy", busy, 1);
    check("regwr_done_dq_oe", dq_oe, 0);
    end_txn();
    check("regwr_idle", busy, 0);
    do_read("rd_w0", 48'hA0_00_00_00_00_00, 2, 32'h3344_0000);

    // Odd byte count: only the high byte of word 5 is committed.
    do_write(48'h20_00_00_00_00_05, 1, 32'h7700_0000, 4'b0000);
    do_read("rd_odd", 48'hA0_00_00_00_00_05, 2, 32'h7734_0000);

    // Reset while the third data byte is on the bus.
    send_ca(48'hA0_00_00_00_00_03);
    n0 = cyc;
    exp_q.push_back('{n0 + LATENCY,     8'hCC, 1'b1});
    exp_q.push_back('{n0 + LATENCY + 1, 8'hCC, 1'b0});
    repeat (LATENCY + 2) tick();
    check("mid_rd_dq_oe_before", dq_oe, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rd_rst_dq_oe", dq_oe, 0);
    check("mid_rd_rst_rwds_oe", rwds_oe, 0);
    check("mid_rd_rst_busy", busy, 0);
    cs_n = 1'b1;
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    check("mid_rd_drained", exp_q.size(), 0);
    do_read("rd_after_rst", 48'hA0_00_00_00_00_05, 2, 32'h7734_0000);

    repeat (4) tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
